// File: rtl/seq_divider.sv
// Sequential restoring divider: unsigned WIDTH-bit dividend / divisor, one quotient bit per clock.
// start/busy/done handshake; quotient, remainder and div_by_zero are registered and held until the next result.
module seq_divider #(
  parameter int WIDTH   = 16,
  parameter int WIDTH_C = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   q_reg;
  logic [WIDTH-1:0]   d_reg;
  logic [WIDTH-1:0]   r_reg;
  logic [WIDTH_C-1:0] cnt;
  logic [WIDTH-1:0]   q_step;
  logic [WIDTH-1:0]   r_step;
  logic               last_step;

  // The shifted partial remainder and trial difference are WIDTH+1 bits wide. A kept remainder
  // is always below the divisor, so the stored copy needs only WIDTH bits.
  function automatic logic [2*WIDTH-1:0] restore_step(input logic [WIDTH-1:0] r,
                                                      input logic [WIDTH-1:0] q,
                                                      input logic [WIDTH-1:0] d);
    logic [WIDTH:0] rs;
    logic [WIDTH:0] t;
    rs = {r, q[WIDTH-1]};
    t  = rs - {1'b0, d};
    if (!t[WIDTH]) restore_step = {t[WIDTH-1:0], q[WIDTH-2:0], 1'b1};
    else           restore_step = {rs[WIDTH-1:0], q[WIDTH-2:0], 1'b0};
  endfunction

  assign {r_step, q_step} = restore_step(r_reg, q_reg, d_reg);
  assign last_step = (cnt == WIDTH_C'(WIDTH - 1));
  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (divisor == '0) ? DONE : CALC;
      CALC:    if (last_step) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_reg       <= '0;
      d_reg       <= '0;
      r_reg       <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          q_reg <= dividend;
          d_reg <= divisor;
          r_reg <= '0;
          cnt   <= '0;
          if (divisor == '0) begin
            quotient    <= '1;
            remainder   <= dividend;
            div_by_zero <= 1'b1;
          end
        end
        CALC: begin
          q_reg <= q_step;
          r_reg <= r_step;
          cnt   <= cnt + 1'b1;
          if (last_step) begin
            quotient    <= q_step;
            remainder   <= r_step;
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed and table-driven checks for seq_divider, plus multi-cycle corner sequences and a random sweep.
module tb_seq_divider;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] dividend, divisor;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  int total = 0;
  int bad   = 0;

  seq_divider #(.WIDTH(W), .WIDTH_C(5)) dut (
    .clk(clk), .reset(reset), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
    int           lat;
  } vec_t;

  vec_t vt[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Presents an operation at a falling edge; returns #1 after the accepting edge with start dropped.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // lat = number of the cycle after the accepting edge in which done is seen (0 on timeout).
  task automatic wait_done(output int lat);
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      if (done) begin
        lat = k;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (lat == 0) begin
      total++;
      bad++;
      $display("FAIL done_timeout actual=none required=done within 40 cycles");
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=still running required=finished");
    $fatal(1);
  end

  initial begin
    int lat, n_done;
    logic [W-1:0] a, b, prev_q;

    vt[0]  = '{16'd100,   16'd7,      16'd14,     16'd2,      1'b0, 17};
    vt[1]  = '{16'hFFFF,  16'h0001,   16'hFFFF,   16'h0000,   1'b0, 17};
    vt[2]  = '{16'hFFFF,  16'h8000,   16'h0001,   16'h7FFF,   1'b0, 17};
    vt[3]  = '{16'd5,     16'd9,      16'd0,      16'd5,      1'b0, 17};
    vt[4]  = '{16'd1234,  16'd0,      16'hFFFF,   16'd1234,   1'b1, 1};
    vt[5]  = '{16'd10,    16'd3,      16'd3,      16'd1,      1'b0, 17};
    vt[6]  = '{16'd500,   16'd7,      16'd71,     16'd3,      1'b0, 17};
    vt[7]  = '{16'd200,   16'd10,     16'd20,     16'd0,      1'b0, 17};
    vt[8]  = '{16'd0,     16'd5,      16'd0,      16'd0,      1'b0, 17};
    vt[9]  = '{16'hFFFF,  16'hFFFF,   16'd1,      16'd0,      1'b0, 17};
    vt[10] = '{16'h8000,  16'hFFFF,   16'd0,      16'h8000,   1'b0, 17};
    vt[11] = '{16'd1000,  16'd33,     16'd30,     16'd10,     1'b0, 17};

    reset = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_quot", quotient, 0);
    chk("rst_rem", remainder, 0);
    chk("rst_dbz", div_by_zero, 0);
    @(negedge clk) reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      launch(vt[i].a, vt[i].b);
      chk($sformatf("v%0d_busy", i), busy, 1);
      wait_done(lat);
      chk($sformatf("v%0d_lat", i), lat, vt[i].lat);
      chk($sformatf("v%0d_quot", i), quotient, vt[i].q);
      chk($sformatf("v%0d_rem", i), remainder, vt[i].r);
      chk($sformatf("v%0d_dbz", i), div_by_zero, vt[i].z);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_done_pulse", i), done, 0);
      chk($sformatf("v%0d_idle", i), busy, 0);
    end

    // Second start and operand changes while computing must not disturb the first request.
    launch(16'd200, 16'd10);
    repeat (3) @(posedge clk);
    @(negedge clk);
    start = 1'b1; dividend = 16'd9; divisor = 16'd3;
    @(posedge clk);
    #1 start = 1'b0; dividend = 16'd1; divisor = 16'd1;
    n_done = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        n_done++;
        chk("ign_quot", quotient, 20);
        chk("ign_rem", remainder, 0);
      end
    end
    chk("ign_done_count", n_done, 1);
    chk("ign_hold_quot", quotient, 20);
    chk("ign_busy", busy, 0);

    // start held high through DONE is taken again only once back in IDLE.
    @(negedge clk);
    dividend = 16'd10; divisor = 16'd3; start = 1'b1;
    @(posedge clk);
    #1;
    wait_done(lat);
    chk("held_lat", lat, 17);
    @(posedge clk);
    #1;
    chk("held_idle_gap", busy, 0);
    @(posedge clk);
    #1;
    chk("held_reaccept", busy, 1);
    start = 1'b0;
    wait_done(lat);
    chk("held_lat2", lat, 17);
    chk("held_quot", quotient, 3);
    chk("held_rem", remainder, 1);
    @(posedge clk);
    #1;

    // Asynchronous reset mid-operation discards it and clears the held results.
    launch(16'd500, 16'd7);
    repeat (8) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_quot", quotient, 0);
    chk("mid_rst_rem", remainder, 0);
    chk("mid_rst_dbz", div_by_zero, 0);
    @(negedge clk) reset = 1'b0;
    n_done = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      #1;
      if (done || busy) n_done++;
    end
    chk("mid_rst_no_done", n_done, 0);
    launch(16'd500, 16'd7);
    wait_done(lat);
    chk("after_rst_lat", lat, 17);
    chk("after_rst_quot", quotient, 71);
    chk("after_rst_rem", remainder, 3);
    @(posedge clk);
    #1;

    prev_q = quotient;
    for (int i = 0; i < 300; i++) begin
      a = 16'($urandom);
      b = (i % 2 == 1) ? 16'($urandom_range(1, 255)) : 16'($urandom);
      if (b == '0) b = 16'd1;
      launch(a, b);
      repeat (4) @(posedge clk);
      #1;
      chk("rnd_hold", quotient, prev_q);
      wait_done(lat);
      chk("rnd_quot", quotient, a / b);
      chk("rnd_rem", remainder, a % b);
      chk("rnd_rem_lt_div", remainder < b, 1);
      prev_q = quotient;
      @(posedge clk);
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
